// File: rtl/bist_response_checker_if.sv
// Handshake and data bundle between a BIST controller and the response checker.
// master: controller / test harness side, drives the control pulses and CUT response.
// slave : checker side, drives the pattern, signature, count and verdict.
interface bist_response_checker_if #(
   parameter int WIDTH = 8
);
   logic             init;
   logic             running;
   logic             toggle;
   logic             finish;
   logic [WIDTH-1:0] cut_out;
   logic [WIDTH-1:0] pattern;
   logic [WIDTH-1:0] signature;
   logic [7:0]       pat_count;
   logic             result_valid;
   logic             pass;
   logic             fail;
   logic             timeout;

   modport master (
      output init, running, toggle, finish, cut_out,
      input  pattern, signature, pat_count, result_valid, pass, fail, timeout
   );

   modport slave (
      input  init, running, toggle, finish, cut_out,
      output pattern, signature, pat_count, result_valid, pass, fail, timeout
   );
endinterface

// File: rtl/bist_response_checker.sv
// BIST response checker: responder side of the init/running/toggle/finish handshake.
// Generates Galois-LFSR patterns for the CUT, folds CUT responses into a MISR
// signature and, on finish, latches a pass/fail verdict until the next init.
// Optional watchdog: define BIST_TIMEOUT_EN to force a timeout verdict when the
// controller never sends finish; without it timeout is tied low.
module bist_response_checker #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] LFSR_SEED  = 8'h01,
   parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8,
   parameter logic [WIDTH-1:0] MISR_TAPS  = 8'hB8,
   parameter int               N_PATTERNS = 16,
   parameter logic [WIDTH-1:0] GOLDEN_SIG = 8'h00,
   parameter int               TIMEOUT    = 8
) (
   input logic clk,
   input logic reset,
   bist_response_checker_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RUN,
      EVAL,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] sig;
   logic [WIDTH-1:0] sig_next;
   logic [WIDTH-1:0] pattern_q;
   logic [WIDTH-1:0] pattern_next;
   logic [7:0]       count;
   logic [7:0]       count_next;
   logic             inv;
   logic             inv_next;
   logic             valid_q;
   logic             valid_next;
   logic             pass_q;
   logic             pass_next;
   logic             fail_q;
   logic             fail_next;
   logic             timeout_q;
   logic             timeout_next;
   logic             compress;
   logic             watchdog_fire;

   // A zero seed would lock the LFSR at zero, so refuse to elaborate with it.
   if (LFSR_SEED == '0 || TIMEOUT < 0) begin : g_bad_config
      $error("bist_response_checker: LFSR_SEED must be nonzero and TIMEOUT non-negative");
   end

`ifdef BIST_TIMEOUT_EN
   localparam int WD_LIMIT = N_PATTERNS + TIMEOUT;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);

   logic [WD_W-1:0] wd_count;
   logic [WD_W-1:0] wd_next;

   // Watchdog counts every cycle spent armed or running; init restarts it.
   always_comb begin
      wd_next = wd_count;
      if (bus.init) begin
         wd_next = '0;
      end else if ((state == ARMED || state == RUN) && !watchdog_fire) begin
         wd_next = wd_count + 1'b1;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_count <= '0;
      end else begin
         wd_count <= wd_next;
      end
   end

   assign watchdog_fire = (state == ARMED || state == RUN) && !bus.finish &&
                          (wd_count == WD_W'(WD_LIMIT - 1));
`else
   assign watchdog_fire = 1'b0;
`endif

   // Next-state logic: init dominates, then per-state handshake handling, then compression.
   always_comb begin
      state_next   = state;
      lfsr_next    = lfsr;
      sig_next     = sig;
      count_next   = count;
      inv_next     = inv;
      valid_next   = valid_q;
      pass_next    = pass_q;
      fail_next    = fail_q;
      timeout_next = timeout_q;
      compress     = 1'b0;

      if (bus.init) begin
         state_next   = ARMED;
         lfsr_next    = LFSR_SEED;
         sig_next     = '0;
         count_next   = '0;
         inv_next     = 1'b0;
         valid_next   = 1'b0;
         pass_next    = 1'b0;
         fail_next    = 1'b0;
         timeout_next = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.finish) begin
                  state_next = DONE;
                  valid_next = 1'b1;
                  pass_next  = 1'b0;
                  fail_next  = 1'b1;
               end
            end
            ARMED, RUN: begin
               compress = bus.running;
               if (bus.toggle) begin
                  inv_next = ~inv;
               end
               if (bus.finish) begin
                  state_next = EVAL;
               end else if (watchdog_fire) begin
                  state_next   = DONE;
                  valid_next   = 1'b1;
                  pass_next    = 1'b0;
                  fail_next    = 1'b1;
                  timeout_next = 1'b1;
               end else if (bus.running) begin
                  state_next = RUN;
               end
            end
            EVAL: begin
               state_next = DONE;
               valid_next = 1'b1;
               pass_next  = (sig == GOLDEN_SIG) && (count == 8'(N_PATTERNS));
               fail_next  = !((sig == GOLDEN_SIG) && (count == 8'(N_PATTERNS)));
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase

         if (compress) begin
            lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
            sig_next  = ((sig >> 1) ^ (sig[0] ? MISR_TAPS : '0)) ^ bus.cut_out;
            if (count != 8'hFF) begin
               count_next = count + 8'd1;
            end
         end
      end

      pattern_next = lfsr_next ^ {WIDTH{inv_next}};
   end

   // State, pattern generator, signature and verdict registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= LFSR_SEED;
         sig       <= '0;
         pattern_q <= LFSR_SEED;
         count     <= '0;
         inv       <= 1'b0;
         valid_q   <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_next;
         lfsr      <= lfsr_next;
         sig       <= sig_next;
         pattern_q <= pattern_next;
         count     <= count_next;
         inv       <= inv_next;
         valid_q   <= valid_next;
         pass_q    <= pass_next;
         fail_q    <= fail_next;
         timeout_q <= timeout_next;
      end
   end

   assign bus.pattern      = pattern_q;
   assign bus.signature    = sig;
   assign bus.pat_count    = count;
   assign bus.result_valid = valid_q;
   assign bus.pass         = pass_q;
   assign bus.fail         = fail_q;
   assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_bist_response_checker.sv
// Self-checking bench for bist_response_checker.
// A behavioural model tracks LFSR, MISR, count and complement phase; expected
// pattern/signature/count are queued when stimulus is driven and popped after the edge.
// Define BIST_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_bist_response_checker;

   localparam int W    = 8;
   localparam int NPAT = 16;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   function automatic logic [7:0] misr_step(input logic [7:0] v);
      return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   // CUT stand-in: rotate left and invert a nibble pattern.
   function automatic logic [7:0] cut_fn(input logic [7:0] p);
      return {p[6:0], p[7]} ^ 8'h3C;
   endfunction

   function automatic logic [7:0] calc_golden();
      logic [7:0] l;
      logic [7:0] s;
      l = 8'h01;
      s = 8'h00;
      for (int k = 0; k < NPAT; k++) begin
         s = misr_step(s) ^ cut_fn(l);
         l = lfsr_step(l);
      end
      return s;
   endfunction

   localparam logic [7:0] GOLDEN = calc_golden();

   logic       clk;
   logic       reset;
   int         n_checks;
   int         n_fail;
   logic [7:0] m_lfsr;
   logic [7:0] m_sig;
   logic [7:0] m_cnt;
   logic       m_inv;
   logic       m_active;
   logic [7:0] exp_pat_q[$];
   logic [7:0] exp_sig_q[$];
   logic [7:0] exp_cnt_q[$];
   logic       exp_pass_q[$];

   bist_response_checker_if #(.WIDTH(W)) bus ();

   bist_response_checker #(
      .WIDTH(W), .LFSR_SEED(8'h01), .LFSR_TAPS(8'hB8), .MISR_TAPS(8'hB8),
      .N_PATTERNS(NPAT), .GOLDEN_SIG(GOLDEN), .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_init();
      m_lfsr   = 8'h01;
      m_sig    = 8'h00;
      m_cnt    = 8'h00;
      m_inv    = 1'b0;
      m_active = 1'b1;
      exp_pat_q.delete();
      exp_sig_q.delete();
      exp_cnt_q.delete();
      exp_pass_q.delete();
   endtask

   task automatic do_init();
      bus.init = 1'b1;
      @(posedge clk);
      #1;
      bus.init = 1'b0;
      model_init();
   endtask

   // One handshake cycle: drive, advance the model, queue expectations, clock.
   task automatic step(input logic run, input logic tog, input logic fin, input logic flip);
      logic [7:0] co;
      co = cut_fn(m_lfsr ^ {8{m_inv}});
      if (flip) co[0] = ~co[0];
      bus.running = run;
      bus.toggle  = tog;
      bus.finish  = fin;
      bus.cut_out = co;
      if (m_active) begin
         if (run) begin
            m_sig  = misr_step(m_sig) ^ co;
            m_lfsr = lfsr_step(m_lfsr);
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
         end
         if (tog) m_inv = ~m_inv;
         if (fin) m_active = 1'b0;
      end
      exp_pat_q.push_back(m_lfsr ^ {8{m_inv}});
      exp_sig_q.push_back(m_sig);
      exp_cnt_q.push_back(m_cnt);
      @(posedge clk);
      #1;
      bus.running = 1'b0;
      bus.toggle  = 1'b0;
      bus.finish  = 1'b0;
   endtask

   // Counts clocks from the finish edge until result_valid, bounded.
   task automatic wait_valid(output int cycles);
      cycles = 1;
      while (bus.result_valid !== 1'b1 && cycles < 8) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      do_init();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.pattern !== 8'h01) begin
         n_fail++;
         $display("[TB] FAIL reset_pattern: got %h, expected 01", bus.pattern);
      end
      n_checks++;
      if (bus.signature !== 8'h00 || bus.pat_count !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_sig_count: got %h/%h, expected 00/00", bus.signature, bus.pat_count);
      end
      n_checks++;
      if ({bus.result_valid, bus.pass, bus.fail, bus.timeout} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_verdict: got %b, expected 0000",
                  {bus.result_valid, bus.pass, bus.fail, bus.timeout});
      end
      #2;
      reset = 1'b0;
      m_active = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_sequence();
      logic [7:0] req [2];
      req[0] = 8'hB8;
      req[1] = 8'h5C;
      do_init();
      n_checks++;
      if (bus.pattern !== 8'h01 || bus.pat_count !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL seq_init: pattern/count %h/%h, expected 01/00", bus.pattern, bus.pat_count);
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         void'(exp_pat_q.pop_front());
         void'(exp_sig_q.pop_front());
         void'(exp_cnt_q.pop_front());
         n_checks++;
         if (bus.pattern !== req[k] || bus.pat_count !== 8'(k + 1)) begin
            n_fail++;
            $display("[TB] FAIL seq_step%0d: pattern/count %h/%h, expected %h/%h",
                     k, bus.pattern, bus.pat_count, req[k], 8'(k + 1));
         end
      end
   endtask

   // Full run; fault variant flips cut_out bit0 on pattern 5 and finishes with running high.
   task automatic test_run(input logic fault);
      logic [7:0] e_pat, e_sig, e_cnt;
      logic       e_pass;
      int         cyc;
      do_init();
      for (int k = 0; k < NPAT; k++) begin
         if (fault && k == NPAT - 1) begin
            exp_pass_q.push_back(1'b0);
            step(1'b1, 1'b0, 1'b1, 1'b0);
         end else begin
            step(1'b1, 1'b0, 1'b0, fault && k == 5);
         end
         e_pat = exp_pat_q.pop_front();
         e_sig = exp_sig_q.pop_front();
         e_cnt = exp_cnt_q.pop_front();
         n_checks++;
         if (bus.pattern !== e_pat || bus.signature !== e_sig || bus.pat_count !== e_cnt) begin
            n_fail++;
            $display("[TB] FAIL run%0d_step%0d: pat/sig/cnt %h/%h/%h, expected %h/%h/%h", fault, k,
                     bus.pattern, bus.signature, bus.pat_count, e_pat, e_sig, e_cnt);
         end
      end
      if (!fault) begin
         exp_pass_q.push_back((m_sig == GOLDEN) && (m_cnt == 8'(NPAT)));
         step(1'b0, 1'b0, 1'b1, 1'b0);
         void'(exp_pat_q.pop_front());
         void'(exp_sig_q.pop_front());
         void'(exp_cnt_q.pop_front());
      end
      n_checks++;
      if (bus.result_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL run%0d_eval_early: result_valid %b, expected 0", fault, bus.result_valid);
      end
      wait_valid(cyc);
      n_checks++;
      if (cyc != 2 || bus.result_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL run%0d_latency: %0d clocks valid=%b, expected 2 clocks valid=1",
                  fault, cyc, bus.result_valid);
      end
      e_pass = exp_pass_q.pop_front();
      n_checks++;
      if (bus.pass !== e_pass || bus.fail !== !e_pass || bus.pass !== !fault) begin
         n_fail++;
         $display("[TB] FAIL run%0d_verdict: pass/fail %b/%b, expected %b/%b",
                  fault, bus.pass, bus.fail, !fault, fault);
      end
      n_checks++;
      if ((bus.signature === GOLDEN) !== !fault || bus.signature !== m_sig) begin
         n_fail++;
         $display("[TB] FAIL run%0d_signature: got %h, model %h, golden %h",
                  fault, bus.signature, m_sig, GOLDEN);
      end
   endtask

   task automatic test_short_and_init();
      int cyc;
      do_init();
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_valid(cyc);
      n_checks++;
      if (bus.pat_count !== 8'd10 || bus.fail !== 1'b1 || bus.pass !== 1'b0 || bus.result_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL short_run: count=%0d pass/fail/valid=%b%b%b, expected 10 011",
                  bus.pat_count, bus.pass, bus.fail, bus.result_valid);
      end
      do_init();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      bus.init    = 1'b1;
      bus.running = 1'b1;
      @(posedge clk);
      #1;
      bus.init    = 1'b0;
      bus.running = 1'b0;
      model_init();
      n_checks++;
      if (bus.pattern !== 8'h01 || bus.signature !== 8'h00 || bus.pat_count !== 8'h00 || bus.result_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL init_mid_run: pat/sig/cnt/valid %h/%h/%h/%b, expected 01/00/00/0",
                  bus.pattern, bus.signature, bus.pat_count, bus.result_valid);
      end
   endtask

   task automatic test_toggle();
      logic [7:0] e_pat, e_sig, e_cnt;
      int         cyc;
      do_init();
      for (int k = 0; k < 7; k++) begin
         step(1'b1, (k == 2 || k == 5), 1'b0, 1'b0);
         e_pat = exp_pat_q.pop_front();
         e_sig = exp_sig_q.pop_front();
         e_cnt = exp_cnt_q.pop_front();
         n_checks++;
         if (bus.pattern !== e_pat || bus.signature !== e_sig || bus.pat_count !== e_cnt) begin
            n_fail++;
            $display("[TB] FAIL toggle_step%0d: pat/sig/cnt %h/%h/%h, expected %h/%h/%h", k,
                     bus.pattern, bus.signature, bus.pat_count, e_pat, e_sig, e_cnt);
         end
         if (k == 2) begin
            n_checks++;
            if (bus.pattern !== ~m_lfsr) begin
               n_fail++;
               $display("[TB] FAIL toggle_inverted: pattern %h, expected %h", bus.pattern, ~m_lfsr);
            end
         end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      wait_valid(cyc);
      exp_pat_q.delete();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      e_pat = exp_pat_q.pop_front();
      n_checks++;
      if (bus.pattern !== e_pat || bus.result_valid !== 1'b1 || bus.pat_count !== 8'd7) begin
         n_fail++;
         $display("[TB] FAIL toggle_in_done: pat/valid/cnt %h/%b/%0d, expected %h/1/7",
                  bus.pattern, bus.result_valid, bus.pat_count, e_pat);
      end
   endtask

   task automatic test_idle_finish();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      m_active = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({bus.result_valid, bus.pass, bus.fail} !== 3'b101) begin
         n_fail++;
         $display("[TB] FAIL idle_finish: valid/pass/fail %b, expected 101",
                  {bus.result_valid, bus.pass, bus.fail});
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({bus.result_valid, bus.pass, bus.fail} !== 3'b101) begin
         n_fail++;
         $display("[TB] FAIL done_finish_ignored: valid/pass/fail %b, expected 101",
                  {bus.result_valid, bus.pass, bus.fail});
      end
      bus.init   = 1'b1;
      bus.finish = 1'b1;
      @(posedge clk);
      #1;
      bus.init   = 1'b0;
      bus.finish = 1'b0;
      model_init();
      step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.result_valid !== 1'b0 || bus.pat_count !== 8'd1 || bus.pattern !== exp_pat_q.pop_front()) begin
         n_fail++;
         $display("[TB] FAIL init_beats_finish: valid/cnt/pat %b/%0d/%h, expected 0/1/b8",
                  bus.result_valid, bus.pat_count, bus.pattern);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      do_init();
      cyc = 0;
`ifdef BIST_TIMEOUT_EN
      while (bus.result_valid !== 1'b1 && cyc < 40) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         cyc++;
      end
      n_checks++;
      if (cyc != NPAT + 8 || {bus.timeout, bus.fail, bus.pass} !== 3'b110) begin
         n_fail++;
         $display("[TB] FAIL timeout_fire: after %0d cycles timeout/fail/pass %b, expected %0d cycles 110",
                  cyc, {bus.timeout, bus.fail, bus.pass}, NPAT + 8);
      end
`else
      for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.timeout !== 1'b0 || bus.result_valid !== 1'b0 || bus.signature !== m_sig) begin
         n_fail++;
         $display("[TB] FAIL no_watchdog: timeout/valid %b%b sig %h, expected 00 sig %h",
                  bus.timeout, bus.result_valid, bus.signature, m_sig);
      end
      for (int k = 0; k < 230; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.pat_count !== 8'hFF || bus.pat_count !== m_cnt) begin
         n_fail++;
         $display("[TB] FAIL count_saturate: got %h, expected ff", bus.pat_count);
      end
`endif
      exp_pat_q.delete();
      exp_sig_q.delete();
      exp_cnt_q.delete();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      m_active    = 1'b0;
      reset       = 1'b1;
      bus.init    = 1'b0;
      bus.running = 1'b0;
      bus.toggle  = 1'b0;
      bus.finish  = 1'b0;
      bus.cut_out = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      $display("[TB] golden signature from model: %h", GOLDEN);
      test_reset();
      test_sequence();
      test_run(1'b0);
      test_run(1'b1);
      test_short_and_init();
      test_toggle();
      test_idle_finish();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
